// File: rtl/ram_slot_arbiter.sv
// Shares one SDRAM command port between the CPU bus and a DMA requester, one access per PHI2 slot.
// Build option RAM_ARB_DMA_EN adds the DMA port and its starvation guard; without it the block is CPU-only.
module ram_slot_arbiter #(
  parameter int RD_LAT     = 5,
  parameter int DMA_STARVE = 3
) (
  input  logic        C8M,
  input  logic        RESET,
  input  logic        PHI2,
  input  logic        CPU_REQ,
  input  logic        CPU_WE,
  input  logic [23:0] CPU_A,
  input  logic [7:0]  CPU_WD,
  output logic [7:0]  CPU_RD,
  output logic        CPU_DONE,
  output logic        CPU_RDY,
  input  logic        DMA_REQ,
  input  logic        DMA_WE,
  input  logic [23:0] DMA_A,
  input  logic [7:0]  DMA_WD,
  output logic        DMA_ACK,
  output logic [7:0]  DMA_RD,
  output logic        DMA_RVALID,
  output logic        RDCMD,
  output logic        WRCMD,
  output logic [23:0] A,
  output logic [7:0]  WRD,
  input  logic [7:0]  RDD,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, CAPT = 2'd2, DONE = 2'd3} state_t;

  localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

  state_t      state, state_nxt;
  logic [1:0]  phi2_sync;
  logic        fall;
  logic        capt;
  logic [2:0]  cnt;
  logic        cpu_slot;
  logic        dma_win, cpu_win, any_win;
  logic        sel_we;
  logic [23:0] sel_a;
  logic [7:0]  sel_wd;

  // Slot start F is the first C8M cycle that sees PHI2 low after it was seen high.
  always_ff @(posedge C8M) begin
    if (RESET) phi2_sync <= 2'b00;
    else       phi2_sync <= {phi2_sync[0], PHI2};
  end

  assign fall = phi2_sync[1] & ~phi2_sync[0];

`ifdef RAM_ARB_DMA_EN
  // DMA handshake: DMA_REQ with stable WE/A/WD is a pending request; DMA_ACK (one cycle at F+1)
  // consumes it, and the requester may raise the next request from the following cycle.
  localparam logic [3:0] STARVE_MAX = 4'(DMA_STARVE);

  logic [3:0] starve;
  logic       forced;

  assign forced  = DMA_REQ && (starve == STARVE_MAX);
  assign dma_win = DMA_REQ && (forced || !CPU_REQ);
  assign sel_we  = dma_win ? DMA_WE : CPU_WE;
  assign sel_a   = dma_win ? DMA_A  : CPU_A;
  assign sel_wd  = dma_win ? DMA_WD : CPU_WD;

  always_ff @(posedge C8M) begin
    if (RESET) begin
      starve  <= 4'd0;
      CPU_RDY <= 1'b1;
    end else begin
      if (fall) begin
        if (!DMA_REQ || dma_win)                starve <= 4'd0;
        else if (cpu_win && starve != STARVE_MAX) starve <= starve + 4'd1;
      end
      CPU_RDY <= !(DMA_REQ && (starve == STARVE_MAX));
    end
  end

  always_ff @(posedge C8M) begin
    if (RESET) begin
      DMA_ACK    <= 1'b0;
      DMA_RVALID <= 1'b0;
      DMA_RD     <= 8'h00;
    end else begin
      DMA_ACK    <= fall && dma_win;
      DMA_RVALID <= capt && RDCMD && !cpu_slot;
      if (capt && RDCMD && !cpu_slot) DMA_RD <= RDD;
    end
  end
`else
  logic unused_dma;

  assign unused_dma = ^{DMA_REQ, DMA_WE, DMA_A, DMA_WD};
  assign dma_win    = 1'b0;
  assign sel_we     = CPU_WE;
  assign sel_a      = CPU_A;
  assign sel_wd     = CPU_WD;
  assign CPU_RDY    = 1'b1;
  assign DMA_ACK    = 1'b0;
  assign DMA_RVALID = 1'b0;
  assign DMA_RD     = 8'h00;
`endif

  assign cpu_win = CPU_REQ && !dma_win;
  assign any_win = cpu_win || dma_win;

  always_ff @(posedge C8M) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (fall) begin
      state_nxt = HOLD;
    end else begin
      case (state)
        HOLD:    if (cnt == LAT_M1) state_nxt = CAPT;
        CAPT:    state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    capt      = (state == CAPT);
    dbg_state = state;
  end

  // The winning command is latched at F and held for the whole slot; idle slots keep the last A/WRD.
  always_ff @(posedge C8M) begin
    if (RESET) begin
      cnt      <= 3'd0;
      cpu_slot <= 1'b0;
      RDCMD    <= 1'b0;
      WRCMD    <= 1'b0;
      A        <= 24'h000000;
      WRD      <= 8'h00;
      CPU_RD   <= 8'h00;
      CPU_DONE <= 1'b0;
    end else begin
      CPU_DONE <= 1'b0;
      if (fall) begin
        cnt      <= 3'd1;
        cpu_slot <= cpu_win;
        RDCMD    <= any_win && !sel_we;
        WRCMD    <= any_win && sel_we;
        if (any_win) begin
          A   <= sel_a;
          WRD <= sel_wd;
        end
        CPU_DONE <= cpu_win && CPU_WE;
      end else if (state == HOLD) begin
        cnt <= cnt + 3'd1;
      end
      if (capt && RDCMD && cpu_slot) begin
        CPU_RD   <= RDD;
        CPU_DONE <= 1'b1;
      end
    end
  end

  // A slot shorter than RD_LAT would silently drop the pending read.
  assert property (@(posedge C8M) disable iff (RESET) !(fall && (state == HOLD) && RDCMD));

endmodule
